// File: rtl/data_sram_responder_pkg.sv
// Shared constants, decode helpers and enums for the data_sram responder slice.
// Mirrors the widths and MMIO offsets of lib/defines.vh.
package data_sram_responder_pkg;

    localparam int unsigned DATA_SRAM_WD = 32;
    localparam int unsigned DATA_SRAM_BE = DATA_SRAM_WD / 8;

    localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hBFAF;
    localparam logic [15:0] LED_OFF           = 16'h0000;
    localparam logic [15:0] TIMER_OFF         = 16'h0004;
    localparam logic [15:0] SCRATCH_OFF       = 16'h0008;
    localparam logic [15:0] ERRCNT_OFF        = 16'h000C;

    typedef enum logic [2:0] {
        MMIO_LED,
        MMIO_TIMER,
        MMIO_SCRATCH,
        MMIO_ERRCNT,
        MMIO_UNMAPPED
    } mmio_reg_e;

    typedef enum logic {
        RSEL_MMIO,
        RSEL_RAM
    } rsel_e;

    // Takes the word part of the MMIO offset; byte-lane bits never affect decode.
    function automatic mmio_reg_e decode_mmio(input logic [13:0] word_off);
        logic [15:0] off;
        off = {word_off, 2'b00};
        case (off)
            LED_OFF:     return MMIO_LED;
            TIMER_OFF:   return MMIO_TIMER;
            SCRATCH_OFF: return MMIO_SCRATCH;
            ERRCNT_OFF:  return MMIO_ERRCNT;
            default:     return MMIO_UNMAPPED;
        endcase
    endfunction

    function automatic logic [DATA_SRAM_WD-1:0] merge_bytes(
        input logic [DATA_SRAM_WD-1:0] old_val,
        input logic [DATA_SRAM_WD-1:0] wdata,
        input logic [DATA_SRAM_BE-1:0] wen
    );
        logic [DATA_SRAM_WD-1:0] res;
        res = old_val;
        for (int unsigned i = 0; i < DATA_SRAM_BE; i++) begin
            if (wen[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_responder_bytewen_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The array has no reset so it maps onto block RAM.
module bytewen_ram
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 14
) (
    input  logic                    clk_i,
    input  logic                    en_i,
    input  logic [DATA_SRAM_BE-1:0] wen_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [DATA_SRAM_WD-1:0] wdata_i,
    output logic [DATA_SRAM_WD-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_SRAM_WD-1:0] mem_q [DEPTH];
    logic [DATA_SRAM_WD-1:0] rdata_q;

    // Read register only loads on a read, so it holds across writes and idle cycles.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int unsigned i = 0; i < DATA_SRAM_BE; i++) begin
                if (wen_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            if (wen_i == '0) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Memory-side responder for the core's data_sram port: byte-writable RAM plus
// an MMIO window holding LED, free-running timer, scratch and error counter.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter int unsigned LED_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_sram_en,
    input  logic [DATA_SRAM_BE-1:0] data_sram_wen,
    input  logic [31:0]             data_sram_addr,
    input  logic [DATA_SRAM_WD-1:0] data_sram_wdata,
    output logic [DATA_SRAM_WD-1:0] data_sram_rdata,
    output logic [LED_W-1:0]        led,
    output logic [31:0]             timer
);

    logic      is_mmio;
    logic      req_rd;
    logic      req_wr;
    logic      ram_en;
    mmio_reg_e mmio_reg;

    logic [DATA_SRAM_WD-1:0] ram_rdata;
    logic [DATA_SRAM_WD-1:0] led_ext;
    logic [DATA_SRAM_WD-1:0] mmio_rdata_d, mmio_rdata_q;
    logic [LED_W-1:0]        led_d, led_q;
    logic [31:0]             timer_d, timer_q;
    logic [31:0]             scratch_d, scratch_q;
    logic [31:0]             errcnt_d, errcnt_q;
    rsel_e                   rsel_d, rsel_q;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^data_sram_addr[1:0];

    assign is_mmio  = (data_sram_addr[31:16] == MMIO_BASE);
    assign req_rd   = data_sram_en && (data_sram_wen == '0);
    assign req_wr   = data_sram_en && (data_sram_wen != '0);
    assign mmio_reg = decode_mmio(data_sram_addr[15:2]);

    // The RAM has no reset of its own; masking with rst drops requests while reset is held.
    assign ram_en = rst && data_sram_en && !is_mmio;

    bytewen_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .en_i    (ram_en),
        .wen_i   (data_sram_wen),
        .addr_i  (data_sram_addr[ADDR_W+1:2]),
        .wdata_i (data_sram_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        led_d     = led_q;
        scratch_d = scratch_q;
        errcnt_d  = errcnt_q;
        timer_d   = timer_q + 32'd1;
        if (is_mmio && req_wr) begin
            case (mmio_reg)
                MMIO_LED: begin
                    for (int unsigned b = 0; b < LED_W; b++) begin
                        if (data_sram_wen[b/8]) begin
                            led_d[b] = data_sram_wdata[b];
                        end
                    end
                end
                MMIO_TIMER:   timer_d   = merge_bytes(timer_q, data_sram_wdata, data_sram_wen);
                MMIO_SCRATCH: scratch_d = merge_bytes(scratch_q, data_sram_wdata, data_sram_wen);
                default: ;
            endcase
        end
        if (is_mmio && data_sram_en && (mmio_reg == MMIO_UNMAPPED) && (errcnt_q != '1)) begin
            errcnt_d = errcnt_q + 32'd1;
        end
    end

    always_comb begin
        led_ext              = '0;
        led_ext[LED_W-1:0]   = led_q;
        case (mmio_reg)
            MMIO_LED:     mmio_rdata_d = led_ext;
            MMIO_TIMER:   mmio_rdata_d = timer_q;
            MMIO_SCRATCH: mmio_rdata_d = scratch_q;
            MMIO_ERRCNT:  mmio_rdata_d = errcnt_q;
            default:      mmio_rdata_d = '0;
        endcase
        rsel_d = is_mmio ? RSEL_MMIO : RSEL_RAM;
    end

    // The source select is captured with the request so RAM and MMIO data both land in N+1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q        <= '0;
            timer_q      <= '0;
            scratch_q    <= '0;
            errcnt_q     <= '0;
            mmio_rdata_q <= '0;
            rsel_q       <= RSEL_MMIO;
        end else begin
            led_q     <= led_d;
            timer_q   <= timer_d;
            scratch_q <= scratch_d;
            errcnt_q  <= errcnt_d;
            if (req_rd) begin
                rsel_q <= rsel_d;
                if (is_mmio) begin
                    mmio_rdata_q <= mmio_rdata_d;
                end
            end
        end
    end

    assign data_sram_rdata = (rsel_q == RSEL_RAM) ? ram_rdata : mmio_rdata_q;
    assign led             = led_q;
    assign timer           = timer_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized and directed bench for data_sram_responder against a word-level
// behavioural model of RAM, MMIO registers and timer.
module tb_data_sram_responder;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;
    logic [31:0] timer;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    data_sram_responder #(
        .ADDR_W    (14),
        .MMIO_BASE (16'hBFAF),
        .LED_W     (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led             (led),
        .timer           (timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply one request for one clock; outputs are sampled 1 ns after the edge.
    task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = e; wen = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        if (be[0]) r[7:0]   = new_v[7:0];
        if (be[1]) r[15:8]  = new_v[15:8];
        if (be[2]) r[23:16] = new_v[23:16];
        if (be[3]) r[31:24] = new_v[31:24];
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
        rst = 1'b1; en = 1'b0;
        n_checks++; if (led !== 16'h0) begin n_errors++; $display("FAIL reset_led: got %h expected %h", led, 16'h0); end
        n_checks++; if (timer !== 32'h0) begin n_errors++; $display("FAIL reset_timer: got %h expected %h", timer, 32'h0); end
        repeat (5) drive(1'b0, 4'h0, 32'h0, 32'h0);
        n_checks++; if (timer !== 32'd5) begin n_errors++; $display("FAIL reset_timer5: got %h expected %h", timer, 32'd5); end
    endtask

    task automatic test_byte_write();
        drive(1'b1, 4'b1111, 32'h0000_0100, 32'h1122_3344);
        drive(1'b1, 4'b0100, 32'h0000_0100, 32'hAABB_CCDD);
        drive(1'b1, 4'b0000, 32'h0000_0100, 32'h0);
        n_checks++; if (rdata !== 32'h11BB_3344) begin n_errors++; $display("FAIL byte_write: got %h expected %h", rdata, 32'h11BB_3344); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_v;
        drive(1'b1, 4'hF, 32'h10, 32'd1);
        drive(1'b1, 4'hF, 32'h14, 32'd2);
        drive(1'b1, 4'hF, 32'h18, 32'd3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'h0, 32'h10 + 32'(4 * i), 32'h0);
            exp_v = 32'(i + 1);
            n_checks++; if (rdata !== exp_v) begin n_errors++; $display("FAIL back_to_back[%0d]: got %h expected %h", i, rdata, exp_v); end
        end
        drive(1'b1, 4'hF, 32'h1C, 32'h0000_0077);
        drive(1'b1, 4'h0, 32'h1C, 32'h0);
        n_checks++; if (rdata !== 32'h77) begin n_errors++; $display("FAIL read_after_write: got %h expected %h", rdata, 32'h77); end
    endtask

    task automatic test_alias();
        drive(1'b1, 4'hF, 32'h0001_0000, 32'hDEAD_BEEF);
        drive(1'b1, 4'h0, 32'h0000_0000, 32'h0);
        n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL alias: got %h expected %h", rdata, 32'hDEAD_BEEF); end
    endtask

    task automatic test_timer_led();
        drive(1'b1, 4'hF, 32'hBFAF_0004, 32'hFFFF_FFFE);
        n_checks++; if (timer !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL timer_write: got %h expected %h", timer, 32'hFFFF_FFFE); end
        drive(1'b0, 4'hF, 32'hBFAF_0004, 32'h0);
        n_checks++; if (timer !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL timer_inc: got %h expected %h", timer, 32'hFFFF_FFFF); end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        n_checks++; if (timer !== 32'h0) begin n_errors++; $display("FAIL timer_wrap: got %h expected %h", timer, 32'h0); end
        drive(1'b1, 4'hF, 32'hBFAF_0000, 32'h0001_A5A5);
        n_checks++; if (led !== 16'hA5A5) begin n_errors++; $display("FAIL led_write: got %h expected %h", led, 16'hA5A5); end
        drive(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
        n_checks++; if (rdata !== 32'h0000_A5A5) begin n_errors++; $display("FAIL led_read: got %h expected %h", rdata, 32'h0000_A5A5); end
        drive(1'b1, 4'hF, 32'hBFAF_0004, 32'h0000_0100);
        drive(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
        n_checks++; if (rdata !== 32'h100) begin n_errors++; $display("FAIL timer_read: got %h expected %h", rdata, 32'h100); end
        n_checks++; if (timer !== 32'h101) begin n_errors++; $display("FAIL timer_after_read: got %h expected %h", timer, 32'h101); end
        drive(1'b1, 4'b0001, 32'hBFAF_0004, 32'h0000_00FF);
        n_checks++; if (timer !== 32'h1FF) begin n_errors++; $display("FAIL timer_lane_write: got %h expected %h", timer, 32'h1FF); end
    endtask

    task automatic test_errcnt();
        drive(1'b1, 4'h0, 32'hBFAF_0010, 32'h0);
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL unmapped_read: got %h expected %h", rdata, 32'h0); end
        drive(1'b1, 4'hF, 32'hBFAF_0020, 32'h1234_5678);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'h0, 32'hBFAF_000C, 32'h0);
            n_checks++; if (rdata !== 32'd2) begin n_errors++; $display("FAIL errcnt_read[%0d]: got %h expected %h", i, rdata, 32'd2); end
        end
        drive(1'b1, 4'hF, 32'hBFAF_000C, 32'h5555_5555);
        drive(1'b1, 4'h0, 32'hBFAF_000C, 32'h0);
        n_checks++; if (rdata !== 32'd2) begin n_errors++; $display("FAIL errcnt_readonly: got %h expected %h", rdata, 32'd2); end
    endtask

    task automatic test_random();
        logic [31:0] m_mem [16];
        logic [31:0] m_led, m_scratch, m_err, m_timer, m_rdata, pre_timer;
        logic [31:0] a, d;
        logic [3:0]  be;
        logic        e;
        logic [15:0] hi;
        logic [13:0] woff;
        int unsigned op, idx;

        m_err = 32'd2;
        drive(1'b1, 4'hF, 32'hBFAF_0000, 32'h0);
        m_led = 32'h0;
        drive(1'b1, 4'hF, 32'hBFAF_0008, 32'h1234_5678);
        m_scratch = 32'h1234_5678;
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = $urandom;
            drive(1'b1, 4'hF, 32'(i) << 2, m_mem[i]);
        end
        drive(1'b1, 4'hF, 32'hBFAF_0004, 32'h0000_1000);
        m_timer = 32'h1000;
        drive(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
        m_rdata = m_scratch;
        m_timer = m_timer + 32'd1;
        n_checks++; if (rdata !== m_rdata) begin n_errors++; $display("FAIL rand_init: got %h expected %h", rdata, m_rdata); end

        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            e  = 1'b1;
            d  = $urandom;
            be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if (op <= 3) begin
                hi = 16'($urandom);
                if (hi == 16'hBFAF) hi = 16'h0000;
                a = {hi, 10'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            end else if (op <= 7) begin
                a = {16'hBFAF, 14'(op - 4), 2'($urandom_range(0, 3))};
            end else if (op == 8) begin
                a = {16'hBFAF, 14'($urandom_range(4, 16383)), 2'($urandom_range(0, 3))};
            end else begin
                e = 1'b0;
                a = $urandom;
            end

            pre_timer = m_timer;
            m_timer   = m_timer + 32'd1;
            if (e) begin
                if (a[31:16] != 16'hBFAF) begin
                    idx = a[5:2];
                    if (be == 4'h0) m_rdata = m_mem[idx];
                    else m_mem[idx] = lane_merge(m_mem[idx], d, be);
                end else begin
                    woff = a[15:2];
                    if (woff > 14'd3) begin
                        if (m_err != 32'hFFFF_FFFF) m_err = m_err + 32'd1;
                        if (be == 4'h0) m_rdata = 32'h0;
                    end else if (be == 4'h0) begin
                        case (woff)
                            14'd0:   m_rdata = m_led;
                            14'd1:   m_rdata = pre_timer;
                            14'd2:   m_rdata = m_scratch;
                            default: m_rdata = m_err;
                        endcase
                    end else begin
                        case (woff)
                            14'd0:   m_led     = lane_merge(m_led, d, be) & 32'h0000_FFFF;
                            14'd1:   m_timer   = lane_merge(pre_timer, d, be);
                            14'd2:   m_scratch = lane_merge(m_scratch, d, be);
                            default: ;
                        endcase
                    end
                end
            end

            drive(e, be, a, d);
            n_checks++; if (rdata !== m_rdata) begin n_errors++; $display("FAIL rand_rdata[%0d]: addr %h got %h expected %h", n, a, rdata, m_rdata); end
            n_checks++; if (led !== m_led[15:0]) begin n_errors++; $display("FAIL rand_led[%0d]: got %h expected %h", n, led, m_led[15:0]); end
            n_checks++; if (timer !== m_timer) begin n_errors++; $display("FAIL rand_timer[%0d]: got %h expected %h", n, timer, m_timer); end
        end
    endtask

    task automatic test_reset_discard();
        drive(1'b1, 4'hF, 32'h0000_0200, 32'hCAFE_F00D);
        drive(1'b1, 4'hF, 32'hBFAF_0000, 32'h0000_1111);
        @(negedge clk);
        rst = 1'b0; en = 1'b1; wen = 4'hF; addr = 32'h0000_0200; wdata = 32'h0;
        #1;
        n_checks++; if (timer !== 32'h0) begin n_errors++; $display("FAIL async_reset_timer: got %h expected %h", timer, 32'h0); end
        n_checks++; if (led !== 16'h0) begin n_errors++; $display("FAIL async_reset_led: got %h expected %h", led, 16'h0); end
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL async_reset_rdata: got %h expected %h", rdata, 32'h0); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 4'h0, 32'h0000_0200, 32'h0);
        n_checks++; if (rdata !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL reset_discard_write: got %h expected %h", rdata, 32'hCAFE_F00D); end
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_back_to_back();
        test_alias();
        test_timer_led();
        test_errcnt();
        test_random();
        test_reset_discard();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
